// File: rtl/inv_sub_shift_addkey.sv
// ---------------------------------------------------------------------------
// inv_sub_shift_addkey
//   Front half of an AES-256 decryption round: InvShiftRows, then InvSubBytes
//   and AddRoundKey, on one 128-bit state. Feeds the InvMixColumns stage.
//   InvShiftRows is applied as the state is captured. InvSubBytes and
//   AddRoundKey then run over N = 16/SBOX_PER_CYCLE cycles, one group of
//   SBOX_PER_CYCLE bytes per cycle, in ascending byte order.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : state_in / round_key / last_in valid
//   in_ready   : block can be accepted (combinational in out_ready)
//   state_in   : cipher state, [127:120] = byte0, byte index = 4*col+row
//   round_key  : round key, same byte mapping, sampled with state_in
//   last_in    : final-round flag, carried alongside the block
//   out_valid  : state_out / last_out valid
//   out_ready  : downstream accepts state_out
//   state_out  : result state, same byte mapping
//   last_out   : last_in of the block on state_out
// ---------------------------------------------------------------------------
module inv_sub_shift_addkey #(
  parameter int SBOX_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         last_out
);

  localparam int N     = 16 / SBOX_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (SBOX_PER_CYCLE != 4 && SBOX_PER_CYCLE != 8 && SBOX_PER_CYCLE != 16) begin : g_bad_param
    $error("inv_sub_shift_addkey: SBOX_PER_CYCLE must be 4, 8 or 16");
  end

  // FIPS-197 inverse S-box; element 0 sits in the most significant byte.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;

  fsm_e             fsm_q;
  logic [CNT_W-1:0] cnt_q;
  logic [127:0]     state_q;
  logic [127:0]     state_d;
  logic [127:0]     key_q;
  logic             last_q;
  logic [127:0]     shifted;
  logic             accept;

  assign in_ready  = (fsm_q == IDLE) | ((fsm_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (fsm_q == DONE);
  assign state_out = state_q;
  assign last_out  = last_q;

  // Capture stage: InvShiftRows, s[r][c] = in[r][(c-r) mod 4].
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127 - 8*(4*c + r) -: 8] = state_in[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
  end

  // Process stage: group cnt_q covers bytes cnt_q*SBOX_PER_CYCLE upward.
  always_comb begin
    state_d = state_q;
    for (int j = 0; j < SBOX_PER_CYCLE; j++) begin
      state_d[127 - 8*(int'(cnt_q)*SBOX_PER_CYCLE + j) -: 8] =
        inv_sbox(state_q[127 - 8*(int'(cnt_q)*SBOX_PER_CYCLE + j) -: 8]) ^
        key_q[127 - 8*(int'(cnt_q)*SBOX_PER_CYCLE + j) -: 8];
    end
  end

  // The key only matters while BUSY, so it is captured without reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      key_q <= round_key;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      last_q  <= 1'b0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (accept) begin
            state_q <= shifted;
            last_q  <= last_in;
            cnt_q   <= '0;
            fsm_q   <= BUSY;
          end
        end
        BUSY: begin
          state_q <= state_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            fsm_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          // Result held until taken; a waiting block is accepted on that same edge.
          if (out_ready) begin
            if (accept) begin
              state_q <= shifted;
              last_q  <= last_in;
              cnt_q   <= '0;
              fsm_q   <= BUSY;
            end else begin
              fsm_q <= IDLE;
            end
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_shift_addkey.sv
// ---------------------------------------------------------------------------
// tb_inv_sub_shift_addkey
//   Bench for inv_sub_shift_addkey with SBOX_PER_CYCLE = 4, 8 and 16
//   (indices 0, 1, 2). The reference inverse S-box is derived from GF(2^8)
//   arithmetic. The reference round is computed byte by byte from the
//   row/column definition. Handshake timing is tracked per instance.
// ---------------------------------------------------------------------------
module tb_inv_sub_shift_addkey;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [3];
  logic         out_ready [3];
  logic         last_in   [3];
  logic [127:0] state_in  [3];
  logic [127:0] round_key [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         last_out  [3];
  logic [127:0] state_out [3];

  always #5 clk = ~clk;

  inv_sub_shift_addkey #(.SBOX_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .state_in(state_in[0]), .round_key(round_key[0]), .last_in(last_in[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .state_out(state_out[0]),
    .last_out(last_out[0])
  );
  inv_sub_shift_addkey #(.SBOX_PER_CYCLE(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .state_in(state_in[1]), .round_key(round_key[1]), .last_in(last_in[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .state_out(state_out[1]),
    .last_out(last_out[1])
  );
  inv_sub_shift_addkey #(.SBOX_PER_CYCLE(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .state_in(state_in[2]), .round_key(round_key[2]), .last_in(last_in[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .state_out(state_out[2]),
    .last_out(last_out[2])
  );

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;

  logic [7:0] inv_tbl [256];

  // Per-instance reference: ph 0 = idle, 1 = processing, 2 = result presented.
  int           ph      [3];
  int           rem     [3];
  int           nper    [3];
  logic [128:0] mexp    [3];
  bit           cleared [3];
  bit           acc     [3];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    logic       hi;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    logic [7:0] s;
    logic [7:0] cst;
    cst = 8'h63;
    for (int i = 0; i < 8; i++) begin
      s[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8] ^ x[(i + 7) % 8] ^ cst[i];
    end
    return s;
  endfunction

  // Forward S-box from multiplicative inverse + affine map, then inverted.
  function automatic void build_tables();
    logic [7:0] ginv;
    for (int x = 0; x < 256; x++) begin
      ginv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) ginv = 8'(y);
      end
      inv_tbl[affine(ginv)] = 8'(x);
    end
  endfunction

  function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key);
    logic [127:0] res;
    logic [7:0]   src;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = st[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
        res[127 - 8*(4*c + r) -: 8] = inv_tbl[src] ^ key[127 - 8*(4*c + r) -: 8];
      end
    end
    return res;
  endfunction

  function automatic void chk_bit(input string nm, input logic a, input logic e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %b want %b (cycle %0d)", nm, a, e, cyc);
    end
  endfunction

  function automatic void chk_vec(input string nm, input logic [128:0] a, input logic [128:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
    end
  endfunction

  function automatic void chk_int(input string nm, input int a, input int e);
    nchk++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, a, e, cyc);
    end
  endfunction

  function automatic void check_all();
    for (int k = 0; k < 3; k++) begin
      chk_bit($sformatf("out_valid[%0d]", k), out_valid[k], ph[k] == 2);
      chk_bit($sformatf("in_ready[%0d]", k), in_ready[k],
              (ph[k] == 0) || (ph[k] == 2 && out_ready[k]));
      if (ph[k] == 2)
        chk_vec($sformatf("out[%0d]", k), {last_out[k], state_out[k]}, mexp[k]);
      if (cleared[k])
        chk_vec($sformatf("cleared[%0d]", k), {last_out[k], state_out[k]}, '0);
    end
  endfunction

  // One clock: advance the reference with the inputs seen at the edge,
  // then compare every instance on the falling edge.
  task automatic tick();
    bit rdy;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      rdy    = (ph[k] == 0) || (ph[k] == 2 && out_ready[k]);
      acc[k] = in_valid[k] && rdy;
      if (rst) begin
        ph[k] = 0; rem[k] = 0; cleared[k] = 1'b1; acc[k] = 1'b0;
      end else if (ph[k] == 1) begin
        rem[k]--;
        if (rem[k] == 0) ph[k] = 2;
      end else if (acc[k]) begin
        ph[k]      = 1;
        rem[k]     = nper[k];
        mexp[k]    = {last_in[k], model(state_in[k], round_key[k])};
        cleared[k] = 1'b0;
      end else if (ph[k] == 2 && out_ready[k]) begin
        ph[k] = 0;
      end
    end
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic run_block(input int k, input logic [127:0] st, input logic [127:0] key,
                           input logic lst, input logic [128:0] lit, input string nm);
    int t;
    state_in[k]  = st;
    round_key[k] = key;
    last_in[k]   = lst;
    in_valid[k]  = 1'b1;
    out_ready[k] = 1'b1;
    tick();
    in_valid[k] = 1'b0;
    t = 0;
    while (t < 20 && !out_valid[k]) begin
      tick();
      t++;
    end
    chk_int({nm, "_latency"}, t, nper[k]);
    chk_vec({nm, "_data"}, {last_out[k], state_out[k]}, lit);
    chk_vec({nm, "_model"}, {lst, model(st, key)}, lit);
  endtask

  // Eight blocks with out_ready held high; the result cycle is separate from
  // the N processing cycles, so results appear N+1 cycles apart.
  task automatic stream(input int k);
    int fed;
    int outs;
    int last_c;
    fed = 0; outs = 0; last_c = -1;
    out_ready[k] = 1'b1;
    for (int n = 0; n < 200 && outs < 8; n++) begin
      in_valid[k] = (fed < 8);
      for (int j = 0; j < 16; j++) begin
        state_in[k][127 - 8*j -: 8]  = 8'(fed*16 + j + k*85);
        round_key[k][127 - 8*j -: 8] = 8'(fed*7 + j*13);
      end
      last_in[k] = fed[0];
      tick();
      if (acc[k]) fed++;
      if (out_valid[k]) begin
        if (outs > 0) chk_int($sformatf("spacing[%0d]", k), cyc - last_c, nper[k] + 1);
        last_c = cyc;
        outs++;
      end
    end
    in_valid[k] = 1'b0;
    chk_int($sformatf("stream_count[%0d]", k), outs, 8);
  endtask

  localparam logic [127:0] V3_IN  = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
  localparam logic [127:0] V3_OUT = 128'h000d0a07_04010e0b_0805020f_0c090603;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    build_tables();
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; last_in[k] = 1'b0;
      state_in[k] = '0;   round_key[k] = '0;
      ph[k] = 0; rem[k] = 0; cleared[k] = 1'b1; acc[k] = 1'b0; mexp[k] = '0;
      nper[k] = 16 / (4 << k);
    end
    chk_int("inv_tbl_00", int'(inv_tbl[8'h00]), 'h52);
    chk_int("inv_tbl_63", int'(inv_tbl[8'h63]), 'h00);
    chk_int("inv_tbl_7c", int'(inv_tbl[8'h7c]), 'h01);

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_bit("reset_in_ready", in_ready[0], 1'b1);
    chk_vec("reset_out", {last_out[0], state_out[0]}, '0);

    run_block(0, '0, '0, 1'b0, {1'b0, {16{8'h52}}}, "zero");
    run_block(0, {16{8'h63}}, {16{8'hff}}, 1'b1, {1'b1, {16{8'hff}}}, "ff_last");
    run_block(0, V3_IN, '0, 1'b0, {1'b0, V3_OUT}, "shift");
    run_block(1, V3_IN, '0, 1'b0, {1'b0, V3_OUT}, "shift8");
    run_block(2, V3_IN, '0, 1'b1, {1'b1, V3_OUT}, "shift16");

    // Backpressure: hold the result ten cycles while a new block waits.
    state_in[0] = V3_IN; round_key[0] = '0; last_in[0] = 1'b0;
    in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    for (int t = 0; t < 20 && !out_valid[0]; t++) tick();
    state_in[0] = '0; round_key[0] = '0; in_valid[0] = 1'b1;
    for (int t = 0; t < 10; t++) tick();
    chk_bit("bp_out_valid", out_valid[0], 1'b1);
    chk_bit("bp_in_ready", in_ready[0], 1'b0);
    chk_vec("bp_held", {last_out[0], state_out[0]}, {1'b0, V3_OUT});
    out_ready[0] = 1'b1;
    #1;
    chk_bit("bp_release_in_ready", in_ready[0], 1'b1);
    tick();
    in_valid[0] = 1'b0;
    chk_bit("bp_taken", out_valid[0], 1'b0);
    seen = 0;
    while (seen < 20 && !out_valid[0]) begin
      tick();
      seen++;
    end
    chk_int("bp_next_latency", seen, 4);
    chk_vec("bp_next_data", {last_out[0], state_out[0]}, {1'b0, {16{8'h52}}});

    stream(0);
    stream(1);
    stream(2);

    // Reset two groups into a block: nothing from it may ever appear.
    state_in[0] = V3_IN; round_key[0] = {16{8'h5a}}; last_in[0] = 1'b1;
    in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_bit("rst_out_valid", out_valid[0], 1'b0);
    chk_bit("rst_in_ready", in_ready[0], 1'b1);
    chk_vec("rst_out", {last_out[0], state_out[0]}, '0);
    seen = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (out_valid[0]) seen++;
    end
    chk_int("rst_no_stale", seen, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
